// File: rtl/dmem_responder.sv
// Data-memory responder for the RV32I load/store path: one request at a time,
// programmable wait states, byte/half/word access with funct3 semantics.
module dmem_responder #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;

  logic        lat_we;
  logic [2:0]  lat_funct3;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  logic [31:0] mem [DEPTH];

  logic              hs_c;
  logic              do_access_c;
  logic              acc_we_c;
  logic [2:0]        acc_funct3_c;
  logic [31:0]       acc_addr_c;
  logic [31:0]       acc_wdata_c;
  logic [ADDR_W-1:0] word_idx_c;
  logic [1:0]        lane_c;
  logic              range_ok_c;
  logic              funct3_ok_c;
  logic              align_ok_c;
  logic              err_c;
  logic [31:0]       rd_word_c;
  logic [7:0]        rd_byte_c;
  logic [15:0]       rd_half_c;
  logic [31:0]       load_data_c;
  logic [3:0]        wmask_c;
  logic [31:0]       wbytes_c;

  assign hs_c = req_valid && (state == S_IDLE);

  // Access happens on the edge that enters RESP; with zero wait states that is
  // the acceptance edge itself, so the live request operands are used then.
  assign do_access_c = (hs_c && (LATENCY == 0)) ||
                       ((state == S_WAIT) && (cnt <= CNT_W'(1)));

  assign acc_we_c     = (state == S_IDLE) ? req_we     : lat_we;
  assign acc_funct3_c = (state == S_IDLE) ? req_funct3 : lat_funct3;
  assign acc_addr_c   = (state == S_IDLE) ? req_addr   : lat_addr;
  assign acc_wdata_c  = (state == S_IDLE) ? req_wdata  : lat_wdata;

  assign word_idx_c = acc_addr_c[ADDR_W+1:2];
  assign lane_c     = acc_addr_c[1:0];
  assign range_ok_c = (acc_addr_c[31:ADDR_W+2] == '0);
  assign rd_word_c  = mem[word_idx_c];

  // Legality, alignment and error decode for the pending access
  always_comb begin
    funct3_ok_c = 1'b0;
    align_ok_c  = 1'b0;
    if (acc_we_c) begin
      funct3_ok_c = (acc_funct3_c == 3'b000) || (acc_funct3_c == 3'b001) ||
                    (acc_funct3_c == 3'b010);
    end else begin
      funct3_ok_c = (acc_funct3_c == 3'b000) || (acc_funct3_c == 3'b001) ||
                    (acc_funct3_c == 3'b010) || (acc_funct3_c == 3'b100) ||
                    (acc_funct3_c == 3'b101);
    end
    case (acc_funct3_c[1:0])
      2'b00:   align_ok_c = 1'b1;
      2'b01:   align_ok_c = !lane_c[0];
      2'b10:   align_ok_c = (lane_c == 2'b00);
      default: align_ok_c = 1'b0;
    endcase
    err_c = !(funct3_ok_c && align_ok_c && range_ok_c);
  end

  // Load lane selection and sign/zero extension
  always_comb begin
    rd_byte_c   = 8'h00;
    load_data_c = 32'h0;
    case (lane_c)
      2'd0:    rd_byte_c = rd_word_c[7:0];
      2'd1:    rd_byte_c = rd_word_c[15:8];
      2'd2:    rd_byte_c = rd_word_c[23:16];
      default: rd_byte_c = rd_word_c[31:24];
    endcase
    rd_half_c = lane_c[1] ? rd_word_c[31:16] : rd_word_c[15:0];
    case (acc_funct3_c)
      3'b000:  load_data_c = {{24{rd_byte_c[7]}}, rd_byte_c};
      3'b001:  load_data_c = {{16{rd_half_c[15]}}, rd_half_c};
      3'b010:  load_data_c = rd_word_c;
      3'b100:  load_data_c = {24'h0, rd_byte_c};
      3'b101:  load_data_c = {16'h0, rd_half_c};
      default: load_data_c = 32'h0;
    endcase
  end

  // Store byte-lane enables and lane-replicated write data
  always_comb begin
    wmask_c  = 4'b0000;
    wbytes_c = 32'h0;
    case (acc_funct3_c[1:0])
      2'b00: begin
        wmask_c  = 4'b0001 << lane_c;
        wbytes_c = {4{acc_wdata_c[7:0]}};
      end
      2'b01: begin
        wmask_c  = lane_c[1] ? 4'b1100 : 4'b0011;
        wbytes_c = {2{acc_wdata_c[15:0]}};
      end
      2'b10: begin
        wmask_c  = 4'b1111;
        wbytes_c = acc_wdata_c;
      end
      default: begin
        wmask_c  = 4'b0000;
        wbytes_c = 32'h0;
      end
    endcase
  end

  // Next-state and wait counter
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      S_IDLE: begin
        if (hs_c) begin
          cnt_next   = CNT_W'(LATENCY);
          state_next = (LATENCY == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_next = cnt - CNT_W'(1);
        if (cnt <= CNT_W'(1)) begin
          state_next = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State register with registered handshake outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      req_ready <= (state_next == S_IDLE);
      rsp_valid <= (state_next == S_RESP);
    end
  end

  // Request capture on handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_we     <= 1'b0;
      lat_funct3 <= 3'b000;
      lat_addr   <= 32'h0;
      lat_wdata  <= 32'h0;
    end else if (hs_c) begin
      lat_we     <= req_we;
      lat_funct3 <= req_funct3;
      lat_addr   <= req_addr;
      lat_wdata  <= req_wdata;
    end
  end

  // Response payload, sampled at the access edge and held through RESP
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else if (do_access_c) begin
      rsp_err   <= err_c;
      rsp_rdata <= (acc_we_c || err_c) ? 32'h0 : load_data_c;
    end
  end

  // Byte-lane memory writes; contents survive reset
  always_ff @(posedge clk) begin
    if (!reset && do_access_c && acc_we_c && !err_c) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask_c[i]) begin
          mem[word_idx_c][8*i +: 8] <= wbytes_c[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: four instances (LATENCY 1, 0, 15, 3).
module tb_dmem_responder;

  logic             clk;
  logic             reset;
  logic [3:0]       req_valid;
  logic [3:0]       req_ready;
  logic [3:0]       req_we;
  logic [3:0][2:0]  req_funct3;
  logic [3:0][31:0] req_addr;
  logic [3:0][31:0] req_wdata;
  logic [3:0]       rsp_valid;
  logic [3:0]       rsp_ready;
  logic [3:0][31:0] rsp_rdata;
  logic [3:0]       rsp_err;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    dmem_responder #(
      .ADDR_W (12),
      .LATENCY((g == 0) ? 1 : (g == 1) ? 0 : (g == 2) ? 15 : 3)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_we    (req_we[g]),
      .req_funct3(req_funct3[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_err   (rsp_err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction with rsp_ready raised once the response appears
  task automatic do_req(input int i, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int exp_lat, input logic exp_err,
                        input logic [31:0] exp_rd, input string tag);
    int n;
    req_we[i]     = we;
    req_funct3[i] = f3;
    req_addr[i]   = a;
    req_wdata[i]  = wd;
    req_valid[i]  = 1'b1;
    chk({tag, ".rdy"}, 32'(req_ready[i]), 32'd1);
    tick();
    req_valid[i] = 1'b0;
    n = 0;
    while (!rsp_valid[i] && n < 40) begin
      tick();
      n++;
    end
    chk({tag, ".lat"}, 32'(n), 32'(exp_lat));
    chk({tag, ".err"}, 32'(rsp_err[i]), 32'(exp_err));
    chk({tag, ".rd"}, rsp_rdata[i], exp_rd);
    rsp_ready[i] = 1'b1;
    tick();
    rsp_ready[i] = 1'b0;
    chk({tag, ".idle"}, {30'h0, rsp_valid[i], req_ready[i]}, 32'd1);
  endtask

  // Back-to-back loads with rsp_ready tied high; measures handshake spacing
  task automatic thru(input int i, input int period, input string tag);
    int   last;
    int   hits;
    logic rr;
    last = -1;
    hits = 0;
    req_we[i]     = 1'b0;
    req_funct3[i] = 3'b010;
    req_addr[i]   = 32'h0;
    req_valid[i]  = 1'b1;
    rsp_ready[i]  = 1'b1;
    for (int c = 0; c < 80 && hits < 4; c++) begin
      rr = req_ready[i];
      tick();
      if (rr) begin
        if (last >= 0) chk(tag, 32'(c - last), 32'(period));
        last = c;
        hits++;
      end
    end
    chk({tag, ".hits"}, 32'(hits), 32'd4);
    req_valid[i] = 1'b0;
    for (int c = 0; c < 40 && !(req_ready[i] && !rsp_valid[i]); c++) tick();
    rsp_ready[i] = 1'b0;
    chk({tag, ".drain"}, {30'h0, rsp_valid[i], req_ready[i]}, 32'd1);
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = '0;
    req_we     = '0;
    req_funct3 = '0;
    req_addr   = '0;
    req_wdata  = '0;
    rsp_ready  = '0;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("rst.rdy", 32'(req_ready[i]), 32'd1);
      chk("rst.vld", 32'(rsp_valid[i]), 32'd0);
      chk("rst.rd", rsp_rdata[i], 32'h0);
      chk("rst.err", 32'(rsp_err[i]), 32'd0);
    end
    reset = 1'b0;
    tick();

    // LATENCY=1: basic store/load and sub-word semantics
    do_req(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1, 1'b0, 32'h0, "sw10");
    do_req(0, 1'b0, 3'b010, 32'h10, 32'h0, 1, 1'b0, 32'hDEADBEEF, "lw10");
    do_req(0, 1'b1, 3'b000, 32'h11, 32'h7F, 1, 1'b0, 32'h0, "sb11");
    do_req(0, 1'b0, 3'b000, 32'h13, 32'h0, 1, 1'b0, 32'hFFFFFFDE, "lb13");
    do_req(0, 1'b0, 3'b100, 32'h13, 32'h0, 1, 1'b0, 32'h000000DE, "lbu13");
    do_req(0, 1'b0, 3'b001, 32'h10, 32'h0, 1, 1'b0, 32'h00007FEF, "lh10");
    do_req(0, 1'b0, 3'b101, 32'h12, 32'h0, 1, 1'b0, 32'h0000DEAD, "lhu12");
    do_req(0, 1'b0, 3'b001, 32'h12, 32'h0, 1, 1'b0, 32'hFFFFDEAD, "lh12");
    do_req(0, 1'b0, 3'b100, 32'h11, 32'h0, 1, 1'b0, 32'h0000007F, "lbu11");

    // Error responses: no side effects, zero data
    do_req(0, 1'b0, 3'b010, 32'h12, 32'h0, 1, 1'b1, 32'h0, "e.lw12");
    do_req(0, 1'b1, 3'b001, 32'h13, 32'hFFFF, 1, 1'b1, 32'h0, "e.sh13");
    do_req(0, 1'b0, 3'b010, 32'h4000, 32'h0, 1, 1'b1, 32'h0, "e.lw4000");
    do_req(0, 1'b0, 3'b011, 32'h10, 32'h0, 1, 1'b1, 32'h0, "e.ld011");
    do_req(0, 1'b1, 3'b100, 32'h10, 32'h55, 1, 1'b1, 32'h0, "e.st100");
    do_req(0, 1'b1, 3'b000, 32'h80000010, 32'h55, 1, 1'b1, 32'h0, "e.sbhi");
    do_req(0, 1'b1, 3'b010, 32'h4010, 32'h0, 1, 1'b1, 32'h0, "e.sw4010");
    do_req(0, 1'b0, 3'b010, 32'h10, 32'h0, 1, 1'b0, 32'hDEAD7FEF, "reread");

    // Halfword store ignores upper wdata bits
    do_req(0, 1'b1, 3'b001, 32'h12, 32'hFFFF1234, 1, 1'b0, 32'h0, "sh12");
    do_req(0, 1'b0, 3'b010, 32'h10, 32'h0, 1, 1'b0, 32'h12347FEF, "lw10b");

    // Backpressure: response held while a follow-on request waits
    req_we[0] = 1'b0; req_funct3[0] = 3'b010; req_addr[0] = 32'h10; req_valid[0] = 1'b1;
    tick();
    req_funct3[0] = 3'b101; req_addr[0] = 32'h12;
    tick();
    for (int c = 0; c < 5; c++) begin
      chk("bp.vld", 32'(rsp_valid[0]), 32'd1);
      chk("bp.rd", rsp_rdata[0], 32'h12347FEF);
      chk("bp.err", 32'(rsp_err[0]), 32'd0);
      chk("bp.rdy", 32'(req_ready[0]), 32'd0);
      tick();
    end
    rsp_ready[0] = 1'b1;
    tick();
    rsp_ready[0] = 1'b0;
    chk("bp.after", {30'h0, rsp_valid[0], req_ready[0]}, 32'd1);
    tick();
    req_valid[0] = 1'b0;
    chk("bp.acc2", 32'(req_ready[0]), 32'd0);
    tick();
    chk("bp.vld2", 32'(rsp_valid[0]), 32'd1);
    chk("bp.rd2", rsp_rdata[0], 32'h00001234);
    rsp_ready[0] = 1'b1;
    tick();
    rsp_ready[0] = 1'b0;

    // LATENCY=0 and LATENCY=15 timing and data
    do_req(1, 1'b1, 3'b010, 32'h40, 32'h11223344, 0, 1'b0, 32'h0, "l0.sw");
    do_req(1, 1'b0, 3'b001, 32'h42, 32'h0, 0, 1'b0, 32'h00001122, "l0.lh");
    do_req(1, 1'b0, 3'b010, 32'h41, 32'h0, 0, 1'b1, 32'h0, "l0.err");
    do_req(2, 1'b1, 3'b010, 32'h44, 32'h8000FFFF, 15, 1'b0, 32'h0, "l15.sw");
    do_req(2, 1'b0, 3'b000, 32'h44, 32'h0, 15, 1'b0, 32'hFFFFFFFF, "l15.lb");
    do_req(2, 1'b0, 3'b101, 32'h46, 32'h0, 15, 1'b0, 32'h00008000, "l15.lhu");
    thru(1, 2, "tp0");
    thru(0, 3, "tp1");
    thru(2, 17, "tp15");

    // Reset during WAIT drops the response and the uncommitted store
    do_req(3, 1'b1, 3'b010, 32'h20, 32'h0BADF00D, 3, 1'b0, 32'h0, "l3.pre");
    do_req(3, 1'b0, 3'b010, 32'h20, 32'h0, 3, 1'b0, 32'h0BADF00D, "l3.prerd");
    req_we[3] = 1'b1; req_funct3[3] = 3'b010; req_addr[3] = 32'h20;
    req_wdata[3] = 32'h12345678; req_valid[3] = 1'b1;
    tick();
    req_valid[3] = 1'b0;
    tick();
    reset = 1'b1;
    req_valid[3] = 1'b1;
    tick();
    chk("mr.rdy", 32'(req_ready[3]), 32'd1);
    chk("mr.vld", 32'(rsp_valid[3]), 32'd0);
    chk("mr.rd", rsp_rdata[3], 32'h0);
    chk("mr.err", 32'(rsp_err[3]), 32'd0);
    reset = 1'b0;
    req_valid[3] = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    chk("mr.quiet", {30'h0, rsp_valid[3], req_ready[3]}, 32'd1);
    do_req(3, 1'b0, 3'b010, 32'h20, 32'h0, 3, 1'b0, 32'h0BADF00D, "mr.lw20");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
